uart_parity_unit: RTL and testbench

Parametrised parity engine for the UART TX and RX paths.
- TX side: computes the parity bit of a parallel word through a one-deep handshaked output register. The register holds its value until the serializer consumes it.
- RX side: accumulates parity bit-serially as the sampler strobes in data bits, then checks the received parity bit and flags a mismatch.
- Supports even, odd, mark and space parity, plus a parity-disabled mode.
- Sits between the UART register file (config) and the TX serializer / RX sampler.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_parity_unit.sv | 131 +++++++++++++
 tb/tb_uart_parity_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART parity engine: parity type encoding,
// RX FSM state encoding and the parity-apply helper.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_typ_e;

    // RX FSM states
    localparam logic [1:0] RX_IDLE = 2'd0;
    localparam logic [1:0] RX_DATA = 2'd1;
    localparam logic [1:0] RX_PAR  = 2'd2;

    // Turn the XOR reduction of the data bits into the parity bit for a type
    function automatic logic par_apply(input logic acc_xor, input par_typ_e typ);
        logic res;
        case (typ)
            PAR_EVEN:  res = acc_xor;
            PAR_ODD:   res = ~acc_xor;
            PAR_MARK:  res = 1'b1;
            PAR_SPACE: res = 1'b0;
            default:   res = acc_xor;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uart_parity_unit.sv
// UART parity engine: handshaked TX parity generation and bit-serial RX
// parity accumulation/check. The two paths are independent.
module uart_parity_unit
    import uart_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH = 8,
    localparam int unsigned CNT_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  par_en,
    input  logic [1:0]            par_typ,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_par_bit,
    output logic                  tx_par_valid,
    input  logic                  tx_par_ack,
    input  logic                  rx_start,
    input  logic                  rx_bit,
    input  logic                  rx_bit_stb,
    output logic                  rx_busy,
    output logic                  rx_done,
    output logic                  rx_par_err
);

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic tx_par_bit_q;
    logic tx_par_valid_q;
    logic tx_accept;

    // With parity disabled an offered word is swallowed without a handshake
    assign tx_accept = tx_valid & tx_ready & par_en;

    // One-deep output register, held until the serializer acks it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_par_bit_q   <= 1'b0;
            tx_par_valid_q <= 1'b0;
        end else if (tx_accept) begin
            tx_par_bit_q   <= par_apply(^tx_data, par_typ_e'(par_typ));
            tx_par_valid_q <= 1'b1;
        end else if (tx_par_ack && tx_par_valid_q) begin
            tx_par_valid_q <= 1'b0;
        end
    end

    assign tx_ready     = ~tx_par_valid_q;
    assign tx_par_bit   = tx_par_bit_q;
    assign tx_par_valid = tx_par_valid_q;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc_q, acc_d;
    logic             en_q, en_d;
    par_typ_e         typ_q, typ_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Next-state logic; rx_start takes priority over any strobe
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        en_d    = en_q;
        typ_d   = typ_q;
        done_d  = 1'b0;
        err_d   = err_q;
        if (rx_start) begin
            state_d = RX_DATA;
            cnt_d   = '0;
            acc_d   = 1'b0;
            en_d    = par_en;
            typ_d   = par_typ_e'(par_typ);
            err_d   = 1'b0;
        end else if (rx_bit_stb) begin
            case (state_q)
                RX_DATA: begin
                    acc_d = acc_q ^ rx_bit;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        if (en_q) begin
                            state_d = RX_PAR;
                        end else begin
                            state_d = RX_IDLE;
                            done_d  = 1'b1;
                            err_d   = 1'b0;
                        end
                    end
                end
                RX_PAR: begin
                    err_d   = (rx_bit != par_apply(acc_q, typ_q));
                    done_d  = 1'b1;
                    state_d = RX_IDLE;
                end
                default: ;
            endcase
        end
    end

    // RX state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            en_q    <= 1'b0;
            typ_q   <= PAR_EVEN;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            en_q    <= en_d;
            typ_q   <= typ_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rx_busy    = (state_q != RX_IDLE);
    assign rx_done    = done_q;
    assign rx_par_err = err_q;

endmodule

// File: tb/tb_uart_parity_unit.sv
// Scoreboard bench for uart_parity_unit: drivers push expected parity
// results into queues, monitors pop and compare when the DUT presents them.
module tb_uart_parity_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       par_en = 1'b0;
    logic [1:0] par_typ = 2'b00;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_par_bit, tx_par_valid;
    logic       tx_par_ack = 1'b0;
    logic       rx_start = 1'b0, rx_bit = 1'b0, rx_bit_stb = 1'b0;
    logic       rx_busy, rx_done, rx_par_err;

    // Second instance with a 5-bit frame, RX side only
    logic [4:0] tx_data5 = '0;
    logic       tx_valid5 = 1'b0, tx_ack5 = 1'b0;
    logic       tx_ready5, tx_bit5, tx_pv5;
    logic       rx_start5 = 1'b0, rx_bit5 = 1'b0, rx_stb5 = 1'b0;
    logic       rx_busy5, rx_done5, rx_err5;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_tx[$];
    logic exp_rx[$];

    always #5 clk = ~clk;

    uart_parity_unit #(.DATA_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .par_en(par_en), .par_typ(par_typ),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_par_bit(tx_par_bit), .tx_par_valid(tx_par_valid), .tx_par_ack(tx_par_ack),
        .rx_start(rx_start), .rx_bit(rx_bit), .rx_bit_stb(rx_bit_stb),
        .rx_busy(rx_busy), .rx_done(rx_done), .rx_par_err(rx_par_err)
    );

    uart_parity_unit #(.DATA_WIDTH(5)) u_dut5 (
        .clk(clk), .rst(rst), .par_en(par_en), .par_typ(par_typ),
        .tx_data(tx_data5), .tx_valid(tx_valid5), .tx_ready(tx_ready5),
        .tx_par_bit(tx_bit5), .tx_par_valid(tx_pv5), .tx_par_ack(tx_ack5),
        .rx_start(rx_start5), .rx_bit(rx_bit5), .rx_bit_stb(rx_stb5),
        .rx_busy(rx_busy5), .rx_done(rx_done5), .rx_par_err(rx_err5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference parity: count ones, then apply the type rule
    function automatic logic model_par(input logic [7:0] d, input int w, input logic [1:0] typ);
        int ones = 0;
        for (int i = 0; i < w; i++) ones += int'(d[i]);
        case (typ)
            2'b00:   return logic'(ones % 2);
            2'b01:   return logic'(1 - ones % 2);
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // TX monitor: each new tx_par_valid presentation consumes one expectation
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (tx_par_valid && !prev_v) begin
                if (exp_tx.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL tx_unexpected_valid: got tx_par_valid=1, expected 0");
                end else begin
                    chk("tx_par_bit", tx_par_bit, exp_tx.pop_front());
                end
            end
            prev_v = tx_par_valid;
        end
    end

    // RX monitor: each rx_done pulse consumes one expected error flag
    always @(negedge clk) begin
        if (!rst && rx_done) begin
            if (exp_rx.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL rx_unexpected_done: got rx_done=1, expected 0");
            end else begin
                chk("rx_par_err", rx_par_err, exp_rx.pop_front());
                chk("rx_busy_at_done", rx_busy, 0);
            end
        end
    end

    task automatic tx_send(input logic [7:0] d, input logic [1:0] typ, input logic en,
                           input int hold);
        @(posedge clk); #1;
        tx_data = d; par_typ = typ; par_en = en; tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0; par_typ = 2'($urandom); par_en = 1'($urandom);
        if (en) exp_tx.push_back(model_par(d, 8, typ));
        @(negedge clk);
        chk("tx_valid_after_accept", tx_par_valid, en);
        chk("tx_ready_after_accept", tx_ready, !en);
        if (en) begin
            repeat (hold) @(negedge clk);
            chk("tx_valid_held", tx_par_valid, 1);
        end
        @(posedge clk); #1 tx_par_ack = 1'b1;
        @(posedge clk); #1 tx_par_ack = 1'b0;
        @(negedge clk);
        chk("tx_ready_after_ack", tx_ready, 1);
        chk("tx_valid_after_ack", tx_par_valid, 0);
    endtask

    task automatic rx_strobe(input logic b);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1 rx_bit_stb = 1'b1; rx_bit = b;
        @(posedge clk); #1 rx_bit_stb = 1'b0; rx_bit = 1'($urandom);
    endtask

    // Optional aborted prelude of abort_bits data bits; the real frame's
    // rx_start then coincides with a strobe that must be ignored.
    task automatic rx_frame(input logic [7:0] d, input logic [1:0] typ, input logic en,
                            input logic pbit, input int abort_bits);
        logic e;
        if (abort_bits > 0) begin
            @(posedge clk); #1 rx_start = 1'b1; par_typ = 2'($urandom); par_en = 1'b1;
            @(posedge clk); #1 rx_start = 1'b0;
            for (int i = 0; i < abort_bits; i++) rx_strobe(1'($urandom));
        end
        @(posedge clk); #1;
        rx_start = 1'b1; par_typ = typ; par_en = en;
        rx_bit_stb = (abort_bits > 0) ? 1'b1 : 1'($urandom); rx_bit = 1'($urandom);
        @(posedge clk); #1;
        rx_start = 1'b0; rx_bit_stb = 1'b0; par_typ = 2'($urandom); par_en = 1'($urandom);
        e = en ? (pbit != model_par(d, 8, typ)) : 1'b0;
        exp_rx.push_back(e);
        @(negedge clk);
        chk("rx_busy_after_start", rx_busy, 1);
        chk("rx_err_cleared", rx_par_err, 0);
        for (int i = 0; i < 8; i++) rx_strobe(d[i]);
        if (en) rx_strobe(pbit);
        @(negedge clk);
        chk("rx_done_latency", rx_done, 1);
        @(negedge clk);
        chk("rx_done_one_cycle", rx_done, 0);
        chk("rx_err_held", rx_par_err, e);
    endtask

    task automatic rx5_frame(input logic [4:0] d, input logic [1:0] typ, input logic pbit);
        @(posedge clk); #1 rx_start5 = 1'b1; par_typ = typ; par_en = 1'b1;
        @(posedge clk); #1 rx_start5 = 1'b0; par_typ = 2'($urandom);
        for (int i = 0; i < 6; i++) begin
            rx_stb5 = 1'b1; rx_bit5 = (i < 5) ? d[i] : pbit;
            @(posedge clk); #1 rx_stb5 = 1'b0;
            if (i < 5) begin
                @(negedge clk);
                chk("rx5_no_early_done", rx_done5, 0);
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        chk("rx5_done_latency", rx_done5, 1);
        chk("rx5_par_err", rx_err5, pbit != model_par({3'b0, d}, 5, typ));
        chk("rx5_busy", rx_busy5, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_tx_ready", tx_ready, 1);
        chk("reset_tx_valid", tx_par_valid, 0);
        chk("reset_tx_bit", tx_par_bit, 0);
        chk("reset_rx_busy", rx_busy, 0);
        chk("reset_rx_done", rx_done, 0);
        chk("reset_rx_err", rx_par_err, 0);

        // Directed TX cases
        tx_send(8'hA5, 2'b00, 1'b1, 2);
        tx_send(8'h07, 2'b01, 1'b1, 0);
        tx_send(8'h00, 2'b10, 1'b1, 1);
        tx_send(8'hFF, 2'b11, 1'b1, 0);
        tx_send(8'h5A, 2'b10, 1'b0, 0);
        // Randomized TX
        for (int i = 0; i < 20; i++)
            tx_send(8'($urandom), 2'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        // Directed RX cases
        rx_frame(8'h03, 2'b00, 1'b1, 1'b0, 0);
        rx_frame(8'h03, 2'b00, 1'b1, 1'b1, 0);
        repeat (3) @(negedge clk);
        chk("rx_err_held_long", rx_par_err, 1);
        rx_frame(8'hFF, 2'b00, 1'b1, 1'b0, 4);
        rx_frame(8'h96, 2'b01, 1'b0, 1'b1, 0);
        // Randomized RX
        for (int i = 0; i < 20; i++)
            rx_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0);

        // 5-bit frames
        rx5_frame(5'b10110, 2'b01, 1'b0);
        rx5_frame(5'b10110, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) rx5_frame(5'($urandom), 2'($urandom), 1'($urandom));

        // Asynchronous reset with TX holding a mark bit and RX mid-DATA
        @(posedge clk); #1 tx_data = 8'h00; par_typ = 2'b10; par_en = 1'b1; tx_valid = 1'b1;
        rx_start = 1'b1;
        @(posedge clk); #1 tx_valid = 1'b0; rx_start = 1'b0;
        exp_tx.push_back(1'b1);
        rx_strobe(1'b1);
        rx_strobe(1'b0);
        @(negedge clk);
        chk("pre_rst_tx_valid", tx_par_valid, 1);
        chk("pre_rst_rx_busy", rx_busy, 1);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("async_rst_tx_valid", tx_par_valid, 0);
        chk("async_rst_tx_bit", tx_par_bit, 0);
        chk("async_rst_tx_ready", tx_ready, 1);
        chk("async_rst_rx_busy", rx_busy, 0);
        chk("async_rst_rx_done", rx_done, 0);
        chk("async_rst_rx_err", rx_par_err, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("tx_queue_drained", exp_tx.size(), 0);
        chk("rx_queue_drained", exp_rx.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
